// File: rtl/dsp_post_adder_acc_if.sv
// ---------------------------------------------------------------------------
// dsp_post_adder_acc_if : operand, control and result bundle of the post-adder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface dsp_post_adder_acc_if;
  logic        CEOPMODE;
  logic        CECARRYIN;
  logic        CEP;
  logic        CECARRYOUT;
  logic [7:0]  OPMODE;
  logic        CARRYIN;
  logic [35:0] M;
  logic [47:0] DAB;
  logic [47:0] C;
  logic [47:0] PCIN;
  logic [47:0] P;
  logic [47:0] PCOUT;
  logic        CARRYOUT;
  logic        CARRYOUTF;

  modport master (
    output CEOPMODE, CECARRYIN, CEP, CECARRYOUT,
    output OPMODE, CARRYIN, M, DAB, C, PCIN,
    input  P, PCOUT, CARRYOUT, CARRYOUTF
  );

  modport slave (
    input  CEOPMODE, CECARRYIN, CEP, CECARRYOUT,
    input  OPMODE, CARRYIN, M, DAB, C, PCIN,
    output P, PCOUT, CARRYOUT, CARRYOUTF
  );
endinterface

`default_nettype wire

// File: rtl/dsp_post_adder_acc.sv
// ---------------------------------------------------------------------------
// dsp_post_adder_acc : DSP48A1 X/Z mux, post-adder/subtracter and P/CARRYOUT regs
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dsp_post_adder_acc #(
  parameter int OPMODEREG  = 1,
  parameter int CARRYINREG = 1,
  parameter int PREG       = 1,
  parameter     CARRYINSEL = "OPMODE5"
) (
  input  wire logic           CLK,
  input  wire logic           RST,
  dsp_post_adder_acc_if.slave bus
);

  logic [7:0]  w_opm;
  logic        w_cin_sel;
  logic        w_cin;
  logic [47:0] w_x;
  logic [47:0] w_z;
  logic [47:0] w_p_fb;
  logic [48:0] w_sum;
  logic [47:0] w_p;
  logic        w_co;
  logic        w_unused;

  // OPMODE[4] and [6] belong to the pre-adder/multiplier stages upstream.
  assign w_unused = ^{w_opm[6], w_opm[4], bus.CARRYIN};

  if (OPMODEREG != 0) begin : g_opm_reg
    logic [7:0] r_opm;
    always_ff @(posedge CLK or posedge RST) begin
      if (RST)               r_opm <= 8'h00;
      else if (bus.CEOPMODE) r_opm <= bus.OPMODE;
    end
    assign w_opm = r_opm;
  end else begin : g_opm_comb
    assign w_opm = bus.OPMODE;
  end

  if (CARRYINSEL == "OPMODE5") begin : g_cin_opmode5
    assign w_cin_sel = bus.OPMODE[5];
  end else if (CARRYINSEL == "CARRYIN") begin : g_cin_port
    assign w_cin_sel = bus.CARRYIN;
  end else begin : g_cin_zero
    assign w_cin_sel = 1'b0;
  end

  if (CARRYINREG != 0) begin : g_cin_reg
    logic r_cin;
    always_ff @(posedge CLK or posedge RST) begin
      if (RST)                r_cin <= 1'b0;
      else if (bus.CECARRYIN) r_cin <= w_cin_sel;
    end
    assign w_cin = r_cin;
  end else begin : g_cin_comb
    assign w_cin = w_cin_sel;
  end

  always_comb begin
    w_x = 48'h0;
    w_z = 48'h0;
    case (w_opm[1:0])
      2'b00:   w_x = 48'h0;
      2'b01:   w_x = {12'h000, bus.M};
      2'b10:   w_x = w_p_fb;
      default: w_x = bus.DAB;
    endcase
    case (w_opm[3:2])
      2'b00:   w_z = 48'h0;
      2'b01:   w_z = bus.PCIN;
      2'b10:   w_z = w_p_fb;
      default: w_z = bus.C;
    endcase
  end

  // Bit 48 is the carry on add and the borrow on subtract.
  always_comb begin
    if (w_opm[7])
      w_sum = {1'b0, w_z} - ({1'b0, w_x} + {48'h0, w_cin});
    else
      w_sum = {1'b0, w_z} + {1'b0, w_x} + {48'h0, w_cin};
  end

  if (PREG != 0) begin : g_preg
    logic [47:0] r_p;
    logic        r_co;
    always_ff @(posedge CLK or posedge RST) begin
      if (RST)          r_p <= 48'h0;
      else if (bus.CEP) r_p <= w_sum[47:0];
    end
    always_ff @(posedge CLK or posedge RST) begin
      if (RST)                 r_co <= 1'b0;
      else if (bus.CECARRYOUT) r_co <= w_sum[48];
    end
    assign w_p    = r_p;
    assign w_co   = r_co;
    assign w_p_fb = r_p;
  end else begin : g_pcomb
    // Without a P register the feedback path would be a combinational loop.
    assign w_p    = w_sum[47:0];
    assign w_co   = w_sum[48];
    assign w_p_fb = 48'h0;
    a_no_p_feedback : assert property (@(posedge CLK) disable iff (RST)
      !((w_opm[1:0] == 2'b10) || (w_opm[3:2] == 2'b10)));
  end

  assign bus.P         = w_p;
  assign bus.PCOUT     = w_p;
  assign bus.CARRYOUT  = w_co;
  assign bus.CARRYOUTF = w_co;

endmodule

`default_nettype wire

// File: tb/tb_dsp_post_adder_acc.sv
// ---------------------------------------------------------------------------
// tb_dsp_post_adder_acc : directed and randomized checks against an arithmetic model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dsp_post_adder_acc;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  // Model state: what each register of the slice should hold.
  logic [47:0] m_p   = 48'h0;
  logic        m_co  = 1'b0;
  logic [7:0]  m_opm = 8'h00;
  logic        m_cin = 1'b0;

  dsp_post_adder_acc_if bus ();

  dsp_post_adder_acc dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  function automatic logic [48:0] ref_sum(input logic [7:0] opm, input logic cin,
                                          input logic [47:0] p, input logic [35:0] m,
                                          input logic [47:0] dab, input logic [47:0] c,
                                          input logic [47:0] pcin);
    longint unsigned x, z, r;
    x = (opm[1:0] == 2'd0) ? 64'd0 : (opm[1:0] == 2'd1) ? 64'(m) :
        (opm[1:0] == 2'd2) ? 64'(p) : 64'(dab);
    z = (opm[3:2] == 2'd0) ? 64'd0 : (opm[3:2] == 2'd1) ? 64'(pcin) :
        (opm[3:2] == 2'd2) ? 64'(p) : 64'(c);
    r = opm[7] ? (z - x - 64'(cin)) : (z + x + 64'(cin));
    return r[48:0];
  endfunction

  // One rising edge: advance the model with pre-edge inputs, settle 1 time unit after.
  task automatic tick();
    logic [48:0] s;
    @(posedge CLK);
    s = ref_sum(m_opm, m_cin, m_p, bus.M, bus.DAB, bus.C, bus.PCIN);
    if (bus.CEP)        m_p   = s[47:0];
    if (bus.CECARRYOUT) m_co  = s[48];
    if (bus.CEOPMODE)   m_opm = bus.OPMODE;
    if (bus.CECARRYIN)  m_cin = bus.OPMODE[5];
    #1;
  endtask

  task automatic zero_model();
    m_p = 48'h0; m_co = 1'b0; m_opm = 8'h00; m_cin = 1'b0;
  endtask

  task automatic pulse_rst();
    RST = 1'b1;
    #2;
    RST = 1'b0;
    zero_model();
  endtask

  task automatic set_ce(input logic [3:0] ce);
    {bus.CEOPMODE, bus.CECARRYIN, bus.CEP, bus.CECARRYOUT} = ce;
  endtask

  task automatic drive(input logic [7:0] opm, input logic [35:0] m, input logic [47:0] dab,
                       input logic [47:0] c, input logic [47:0] pcin);
    bus.OPMODE = opm; bus.M = m; bus.DAB = dab; bus.C = c; bus.PCIN = pcin;
  endtask

  task automatic test_reset();
    #3;
    n_vec++;
    if ({bus.P, bus.PCOUT, bus.CARRYOUT, bus.CARRYOUTF} !== 98'h0) begin
      n_err++;
      $display("FAIL reset_state: P=%h PCOUT=%h CO=%b COF=%b, required all 0",
               bus.P, bus.PCOUT, bus.CARRYOUT, bus.CARRYOUTF);
    end
    set_ce(4'hF);
    drive(8'h0D, 36'd25, 48'h0, 48'd100, 48'h0);
    @(posedge CLK); #1;
    n_vec++;
    if (bus.P !== 48'h0 || bus.CARRYOUT !== 1'b0) begin
      n_err++;
      $display("FAIL reset_beats_ce: P=%h CO=%b, required 0/0", bus.P, bus.CARRYOUT);
    end
    RST = 1'b0;
    zero_model();
  endtask

  task automatic test_add();
    set_ce(4'hF);
    drive(8'b0000_1101, 36'd25, 48'h0, 48'd100, 48'h0);
    tick(); tick();
    n_vec++;
    if (bus.P !== 48'd125 || bus.CARRYOUT !== 1'b0 || bus.PCOUT !== 48'd125 || bus.CARRYOUTF !== 1'b0) begin
      n_err++;
      $display("FAIL add: P=%0d PCOUT=%0d CO=%b COF=%b, required 125/125/0/0",
               bus.P, bus.PCOUT, bus.CARRYOUT, bus.CARRYOUTF);
    end
  endtask

  task automatic test_sub();
    set_ce(4'hF);
    drive(8'b1000_1101, 36'd6, 48'h0, 48'd5, 48'h0);
    tick(); tick();
    n_vec++;
    if (bus.P !== 48'hFFFF_FFFF_FFFF || bus.CARRYOUT !== 1'b1 || bus.CARRYOUTF !== 1'b1) begin
      n_err++;
      $display("FAIL sub_borrow: P=%h CO=%b COF=%b, required ffffffffffff/1/1",
               bus.P, bus.CARRYOUT, bus.CARRYOUTF);
    end
  endtask

  task automatic test_mac();
    pulse_rst();
    drive(8'b0000_1001, 36'd3, 48'h0, 48'h0, 48'h0);
    set_ce(4'b1100);
    tick();
    n_vec++;
    if (bus.P !== 48'h0) begin
      n_err++;
      $display("FAIL mac_start: P=%0d, required 0", bus.P);
    end
    set_ce(4'hF);
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_vec++;
      if (bus.P !== 48'(3 * i)) begin
        n_err++;
        $display("FAIL mac_step%0d: P=%0d, required %0d", i, bus.P, 3 * i);
      end
    end
    set_ce(4'b1101);
    bus.M = 36'd7;
    tick(); tick();
    n_vec++;
    if (bus.P !== 48'd12 || bus.CARRYOUT !== m_co) begin
      n_err++;
      $display("FAIL mac_hold: P=%0d CO=%b, required 12/%b", bus.P, bus.CARRYOUT, m_co);
    end
  endtask

  task automatic test_overflow();
    set_ce(4'hF);
    drive(8'b0010_1111, 36'h0, 48'h0, 48'hFFFF_FFFF_FFFF, 48'h0);
    tick(); tick();
    n_vec++;
    if (bus.P !== 48'h0 || bus.CARRYOUT !== 1'b1) begin
      n_err++;
      $display("FAIL overflow: P=%h CO=%b, required 0/1", bus.P, bus.CARRYOUT);
    end
  endtask

  task automatic test_opmode_latency();
    set_ce(4'hF);
    drive(8'b0000_1101, 36'd25, 48'h0, 48'd100, 48'h0);
    tick(); tick();
    bus.OPMODE = 8'b1000_1101;
    tick();
    n_vec++;
    if (bus.P !== 48'd125) begin
      n_err++;
      $display("FAIL opm_latency_k1: P=%0d, required 125", bus.P);
    end
    tick();
    n_vec++;
    if (bus.P !== 48'd75) begin
      n_err++;
      $display("FAIL opm_latency_k2: P=%0d, required 75", bus.P);
    end
    set_ce(4'b0111);
    bus.OPMODE = 8'b0000_1101;
    tick(); tick();
    n_vec++;
    if (bus.P !== 48'd75) begin
      n_err++;
      $display("FAIL opm_ce_hold: P=%0d, required 75", bus.P);
    end
  endtask

  task automatic test_async_mid();
    pulse_rst();
    set_ce(4'hF);
    drive(8'b0000_1001, 36'd5, 48'h0, 48'h0, 48'h0);
    tick(); tick(); tick();
    n_vec++;
    if (bus.P !== 48'd10) begin
      n_err++;
      $display("FAIL async_pre: P=%0d, required 10", bus.P);
    end
    #3;
    RST = 1'b1;
    #1;
    n_vec++;
    if (bus.P !== 48'h0 || bus.CARRYOUT !== 1'b0 || bus.PCOUT !== 48'h0) begin
      n_err++;
      $display("FAIL async_immediate: P=%0d CO=%b PCOUT=%0d, required 0", bus.P, bus.CARRYOUT, bus.PCOUT);
    end
    @(posedge CLK); #1;
    RST = 1'b0;
    zero_model();
    tick(); tick();
    n_vec++;
    if (bus.P !== 48'd5 || bus.P !== m_p) begin
      n_err++;
      $display("FAIL async_resume: P=%0d, required 5", bus.P);
    end
  endtask

  task automatic test_random();
    logic [63:0] r;
    for (int i = 0; i < 400; i++) begin
      r = {$urandom(), $urandom()};
      bus.OPMODE  = 8'($urandom());
      bus.M       = r[35:0];
      r = {$urandom(), $urandom()};
      bus.DAB     = r[47:0];
      r = {$urandom(), $urandom()};
      bus.C       = ($urandom_range(0, 3) == 0) ? 48'hFFFF_FFFF_FFFF : r[47:0];
      r = {$urandom(), $urandom()};
      bus.PCIN    = r[47:0];
      bus.CARRYIN = 1'($urandom());
      set_ce({($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 8),
              ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 8)});
      if ($urandom_range(0, 39) == 0) pulse_rst();
      tick();
      n_vec++;
      if (bus.P !== m_p || bus.CARRYOUT !== m_co || bus.PCOUT !== m_p || bus.CARRYOUTF !== m_co) begin
        n_err++;
        $display("FAIL random[%0d]: P=%h CO=%b PCOUT=%h COF=%b, required P=%h CO=%b",
                 i, bus.P, bus.CARRYOUT, bus.PCOUT, bus.CARRYOUTF, m_p, m_co);
      end
    end
  endtask

  initial begin
    set_ce(4'h0);
    drive(8'h00, 36'h0, 48'h0, 48'h0, 48'h0);
    bus.CARRYIN = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_mac();
    test_overflow();
    test_opmode_latency();
    test_async_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
